// File: rtl/uart_pkt_parser.sv
// Frames UART byte strobes into SYNC/CMD/LEN/payload/CHK packets and replays
// validated payloads as a ready/valid stream. Optional idle timeout: UART_PKT_TIMEOUT_EN.
module uart_pkt_parser #(
  parameter int         MAX_LEN     = 16,
  parameter logic [7:0] SYNC_BYTE   = 8'hAA,
  parameter int         TIMEOUT_CYC = 208340
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx_done,
  input  logic [7:0] i_data,
  output logic       o_pkt_valid,
  output logic [7:0] o_cmd,
  output logic [7:0] o_len,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  input  logic       i_byte_ready,
  output logic       o_pkt_done,
  output logic       o_err,
  output logic [1:0] o_err_code,
  output logic       o_drop
);

  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] ERR_CHK     = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_OUT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  wr_idx_q, wr_idx_d;
  logic [7:0]  rd_idx_q, rd_idx_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        drop_q, drop_d;
  logic        wr_en;
  logic        byte_valid;
  logic        xfer;
  logic        pkt_done;
  logic [7:0]  mem_q [MAX_LEN];

`ifdef UART_PKT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_frame;
  logic          to_hit;

  // Fires on the cycle whose increment would bring the idle count to TIMEOUT_CYC-1.
  assign in_frame = (state_q == S_CMD) || (state_q == S_LEN) ||
                    (state_q == S_PAYLOAD) || (state_q == S_CHK);
  assign to_hit   = in_frame && !i_rx_done && (cnt_q == CW'(TIMEOUT_CYC - 2));

  always_comb begin
    cnt_d = cnt_q;
    if (i_rx_done) begin
      cnt_d = '0;
    end else if (in_frame) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign byte_valid = (state_q == S_OUT) && (rd_idx_q < len_q);
  assign xfer       = byte_valid && i_byte_ready;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    chk_d      = chk_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    drop_d     = 1'b0;
    wr_en      = 1'b0;
    pkt_done   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_rx_done && (i_data == SYNC_BYTE)) begin
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (i_rx_done) begin
          cmd_d   = i_data;
          chk_d   = i_data;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (i_rx_done) begin
          len_d = i_data;
          chk_d = chk_q ^ i_data;
          if (i_data > MAX_LEN_B) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = S_IDLE;
          end else if (i_data == 8'd0) begin
            state_d = S_CHK;
          end else begin
            wr_idx_d = 8'd0;
            state_d  = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (i_rx_done) begin
          wr_en    = 1'b1;
          chk_d    = chk_q ^ i_data;
          wr_idx_d = wr_idx_q + 8'd1;
          if (wr_idx_q + 8'd1 == len_q) begin
            state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (i_rx_done) begin
          if (i_data == chk_q) begin
            rd_idx_d = 8'd0;
            state_d  = S_OUT;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
            state_d    = S_IDLE;
          end
        end
      end
      S_OUT: begin
        // The replay buffer is busy; anything the UART delivers now is lost.
        drop_d = i_rx_done;
        if (len_q == 8'd0) begin
          pkt_done = 1'b1;
          state_d  = S_IDLE;
        end else if (xfer) begin
          rd_idx_d = rd_idx_q + 8'd1;
          if (rd_idx_q == len_q - 8'd1) begin
            pkt_done = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef UART_PKT_TIMEOUT_EN
    if (to_hit) begin
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = S_IDLE;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= 8'd0;
      len_q      <= 8'd0;
      chk_q      <= 8'd0;
      wr_idx_q   <= 8'd0;
      rd_idx_q   <= 8'd0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      chk_q      <= chk_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      drop_q     <= drop_d;
    end
  end

  // Payload storage carries no reset; contents only matter after a full write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx_q[AW-1:0]] <= i_data;
    end
  end

  assign o_pkt_valid  = (state_q == S_OUT);
  assign o_cmd        = cmd_q;
  assign o_len        = len_q;
  assign o_byte       = byte_valid ? mem_q[rd_idx_q[AW-1:0]] : 8'd0;
  assign o_byte_valid = byte_valid;
  assign o_pkt_done   = pkt_done;
  assign o_err        = err_q;
  assign o_err_code   = err_code_q;
  assign o_drop       = drop_q;

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed bench for uart_pkt_parser: frame-level queue model checked every cycle,
// plus literal per-packet / per-error expectations.
module tb_uart_pkt_parser;

  localparam int         MAX_LEN = 16;
  localparam logic [7:0] SYNC    = 8'hAA;
  localparam int         TO_CYC  = 100;

`ifdef UART_PKT_TIMEOUT_EN
  localparam int N_PKT = 6;
  localparam int N_ERR = 3;
`else
  localparam int N_PKT = 7;
  localparam int N_ERR = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] data = 8'd0;
  logic       ready = 1'b1;
  logic       tb_done = 1'b0;
  logic       pkt_valid, byte_valid, pkt_done, err, drop;
  logic [7:0] cmd, len, obyte;
  logic [1:0] err_code;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  uart_pkt_parser #(
    .MAX_LEN    (MAX_LEN),
    .SYNC_BYTE  (SYNC),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rx_done   (rx_done),
    .i_data      (data),
    .o_pkt_valid (pkt_valid),
    .o_cmd       (cmd),
    .o_len       (len),
    .o_byte      (obyte),
    .o_byte_valid(byte_valid),
    .i_byte_ready(ready),
    .o_pkt_done  (pkt_done),
    .o_err       (err),
    .o_err_code  (err_code),
    .o_drop      (drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed expectations, in the order packets / errors occur.
  logic [7:0] lit_cmd [7] = '{8'h01, 8'h01, 8'h05, 8'h02, 8'h01, 8'h02, 8'h01};
  logic [7:0] lit_len [7] = '{8'h03, 8'h03, 8'h00, 8'h01, 8'h03, 8'h01, 8'h03};
  logic [7:0] lit_b0  [7] = '{8'h10, 8'h10, 8'h00, 8'h7F, 8'h10, 8'h7F, 8'h10};
  logic [1:0] lit_err [3] = '{2'd1, 2'd2, 2'd3};

  // Frame-level model state.
  logic [7:0] fq[$];
  logic [7:0] out_q[$];
  logic       out_active = 1'b0;
  logic [7:0] out_cmd = 8'd0;
  logic [7:0] out_len = 8'd0;
  logic       pend_err = 1'b0;
  logic [1:0] pend_code = 2'd0;
  logic       pend_drop = 1'b0;
  logic       pend_start = 1'b0;
  logic [1:0] hold_code = 2'd0;
  int         idle = 0;
  int         last_rx = 0;
  int         pkt_no = 0;
  int         err_no = 0;
  int         drop_no = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] x;
    int n;
    if (fq.size() == 0 && b != SYNC) return;
    fq.push_back(b);
    n = fq.size();
    if (n == 3 && int'(fq[2]) > MAX_LEN) begin
      pend_err  = 1'b1;
      pend_code = 2'd2;
      fq.delete();
    end else if (n >= 3 && n == int'(fq[2]) + 4) begin
      x = 8'd0;
      for (int i = 1; i < n - 1; i++) x = x ^ fq[i];
      if (x == fq[n-1]) begin
        pend_start = 1'b1;
        out_cmd = fq[1];
        out_len = fq[2];
        out_q.delete();
        for (int i = 3; i < n - 1; i++) out_q.push_back(fq[i]);
      end else begin
        pend_err  = 1'b1;
        pend_code = 2'd1;
      end
      fq.delete();
    end
  endtask

  always @(negedge clk) begin
    logic first, exp_bv, xfer, exp_done;
    if (rst) begin
      chk("rst_pkt_valid", int'(pkt_valid), 0);
      chk("rst_byte_valid", int'(byte_valid), 0);
      chk("rst_pkt_done", int'(pkt_done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_err_code", int'(err_code), 0);
      chk("rst_drop", int'(drop), 0);
      chk("rst_cmd", int'(cmd), 0);
      chk("rst_len", int'(len), 0);
      fq.delete();
      out_q.delete();
      out_active = 1'b0;
      pend_err = 1'b0;
      pend_drop = 1'b0;
      pend_start = 1'b0;
      hold_code = 2'd0;
      idle = 0;
    end else begin
      first = pend_start;
      if (pend_start) out_active = 1'b1;
      chk("err", int'(err), int'(pend_err));
      if (pend_err) hold_code = pend_code;
      chk("err_code", int'(err_code), int'(hold_code));
      chk("drop", int'(drop), int'(pend_drop));
      chk("pkt_valid", int'(pkt_valid), int'(out_active));
      if (out_active) begin
        chk("cmd", int'(cmd), int'(out_cmd));
        chk("len", int'(len), int'(out_len));
      end
      exp_bv = out_active && (out_q.size() > 0);
      chk("byte_valid", int'(byte_valid), int'(exp_bv));
      if (exp_bv) chk("byte", int'(obyte), int'(out_q[0]));
      xfer = exp_bv && ready;
      exp_done = out_active && (out_len == 8'd0 || (xfer && out_q.size() == 1));
      chk("pkt_done", int'(pkt_done), int'(exp_done));

      if (first) begin
        if (pkt_no < N_PKT) begin
          chk("lit_cmd", int'(cmd), int'(lit_cmd[pkt_no]));
          chk("lit_len", int'(len), int'(lit_len[pkt_no]));
          if (lit_len[pkt_no] != 8'd0) chk("lit_b0", int'(obyte), int'(lit_b0[pkt_no]));
        end else begin
          chk("extra_pkt", int'(pkt_valid), 0);
        end
        pkt_no++;
      end
      if (err) begin
        if (err_no < N_ERR) chk("lit_err_code", int'(err_code), int'(lit_err[err_no]));
        else chk("extra_err", int'(err), 0);
        if (err_code == 2'd3) chk("timeout_latency", cyc - last_rx, TO_CYC);
        err_no++;
      end
      if (drop) drop_no++;

      pend_err = 1'b0;
      pend_drop = 1'b0;
      pend_start = 1'b0;
      if (xfer) void'(out_q.pop_front());
      if (rx_done) begin
        if (out_active) pend_drop = 1'b1;
        else model_byte(data);
        last_rx = cyc;
        idle = 0;
      end else begin
        idle++;
`ifdef UART_PKT_TIMEOUT_EN
        if (!out_active && fq.size() > 0 && idle == TO_CYC - 1) begin
          pend_err = 1'b1;
          pend_code = 2'd3;
          fq.delete();
        end
`endif
      end
      if (exp_done) out_active = 1'b0;
    end

    if (tb_done) begin
      chk("pkt_count", pkt_no, N_PKT);
      chk("err_count", err_no, N_ERR);
      chk("drop_count", drop_no, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] b);
    rx_done = 1'b1;
    data = b;
    step();
    rx_done = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s [8], input int n);
    for (int i = 0; i < n; i++) send(s[i]);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle_n(2);

    // Good 3-byte packet, then bad checksum followed by the good one again.
    send_seq('{8'hAA, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h02, 8'h00}, 7);
    idle_n(8);
    send_seq('{8'hAA, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h03, 8'h00}, 7);
    idle_n(8);
    send_seq('{8'hAA, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h02, 8'h00}, 7);
    idle_n(8);

    // Leading junk, then a zero-length packet.
    send_seq('{8'h55, 8'hAA, 8'h05, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00}, 5);
    idle_n(8);

    // Oversized LEN, then a 1-byte packet.
    send_seq('{8'hAA, 8'h01, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    idle_n(5);
    send_seq('{8'hAA, 8'h02, 8'h01, 8'h7F, 8'h7C, 8'h00, 8'h00, 8'h00}, 5);
    idle_n(8);

    // Back-pressure for 50 cycles with a SYNC byte arriving mid-delivery.
    ready = 1'b0;
    send_seq('{8'hAA, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h02, 8'h00}, 7);
    idle_n(10);
    send(8'hAA);
    idle_n(39);
    ready = 1'b1;
    idle_n(10);

    // Reset in the middle of a frame, then a fresh packet.
    send_seq('{8'hAA, 8'h01, 8'h03, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    idle_n(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_n(3);
    send_seq('{8'hAA, 8'h02, 8'h01, 8'h7F, 8'h7C, 8'h00, 8'h00, 8'h00}, 5);
    idle_n(8);

    // Long silence inside a frame, then the rest of it.
    send_seq('{8'hAA, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
    idle_n(150);
    send_seq('{8'h03, 8'h10, 8'h20, 8'h30, 8'h02, 8'h00, 8'h00, 8'h00}, 5);
    idle_n(10);

    tb_done = 1'b1;
    idle_n(5);
    $display("FAIL end_of_run summary not reached");
    $fatal(1);
  end

endmodule
